// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared FSM state encoding and word geometry for the instruction memory loader
package imem_loader_pkg;
    localparam int BYTES_PER_WORD = 4;
    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;
endpackage

// File: rtl/imem_byte_packer.sv
// imem_byte_packer: assembles little-endian bytes into a 32-bit word
//   clk, reset (async active-low) | clear: restart at byte 0 | take: byte transfer this cycle
//   byte_data: incoming byte | word: assembly register | word_full: this transfer completes the word
module imem_byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        take,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_full
);
    logic [1:0] byte_cnt;

    assign word_full = take && byte_cnt == 2'(BYTES_PER_WORD - 1);

    // byte_cnt wraps to 0 on the fourth byte, so the next word starts clean
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_cnt <= '0;
            word     <= '0;
        end else if (clear) begin
            byte_cnt <= '0;
        end else if (take) begin
            word[{byte_cnt, 3'b000} +: 8] <= byte_data;
            byte_cnt                      <= byte_cnt + 2'd1;
        end
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams program bytes into instruction memory while holding the CPU in reset
//   clk, reset (async active-low) | start, load_len: request a load of load_len words
//   byte_valid, byte_data, byte_ready: byte stream handshake
//   wr_en, wr_addr, wr_data: instruction memory write port
//   cpu_reset_n: released only after a successful load | busy, done, err: status
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [15:0]       load_len,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              cpu_reset_n,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int          IW      = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [16:0] DEPTH_L = 17'(DEPTH_WORDS);

    state_t          state, state_nx;
    logic [IW-1:0]   word_idx;
    logic [15:0]     len_q;
    logic            accept, bad_len, last, word_full;

    assign accept  = start && (state == S_IDLE || state == S_DONE || state == S_ERROR);
    assign bad_len = load_len == 16'd0 || {1'b0, load_len} > DEPTH_L;
    assign last    = 16'(word_idx) + 16'd1 == len_q;
    assign wr_addr = ADDR_W'(word_idx) << 2;

    imem_byte_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (accept),
        .take      (byte_valid && byte_ready),
        .byte_data (byte_data),
        .word      (wr_data),
        .word_full (word_full)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_COLLECT: state_nx = word_full ? S_WRITE : S_COLLECT;
            S_WRITE:   state_nx = last ? S_DONE : S_COLLECT;
            default:   state_nx = accept ? (bad_len ? S_ERROR : S_COLLECT) : state;
        endcase
    end

    // every output is a pure decode of the state register
    always_comb begin
        byte_ready  = state == S_COLLECT;
        wr_en       = state == S_WRITE;
        busy        = state == S_COLLECT || state == S_WRITE;
        done        = state == S_DONE;
        err         = state == S_ERROR;
        cpu_reset_n = state == S_DONE;
    end

    // len_q is only consulted in WRITE, so loading it on a rejected start is harmless
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_idx <= '0;
            len_q    <= '0;
        end else if (accept) begin
            word_idx <= '0;
            len_q    <= load_len;
        end else if (state == S_WRITE && !last) begin
            word_idx <= word_idx + IW'(1);
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized scoreboard bench for imem_loader
module tb_imem_loader;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] load_len = '0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = '0;
    logic        byte_ready, wr_en, cpu_reset_n, busy, done, err;
    logic [31:0] wr_addr, wr_data;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    int          vectors = 0;
    int          miscompares = 0;
    logic [7:0]  prog [256];
    wr_t         exp_q [$];

    imem_loader dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .load_len    (load_len),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_ready  (byte_ready),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .cpu_reset_n (cpu_reset_n),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (wr_en) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_wr: got addr %h data %h expected no write at %0t", wr_addr, wr_data, $time);
            end else begin
                e = exp_q.pop_front();
                check32("wr_addr", wr_addr, e.addr);
                check32("wr_data", wr_data, e.data);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check1({tag, "_byte_ready"}, byte_ready, 1'b0);
        check1({tag, "_wr_en"}, wr_en, 1'b0);
        check32({tag, "_wr_addr"}, wr_addr, 32'h0);
        check32({tag, "_wr_data"}, wr_data, 32'h0);
        check1({tag, "_busy"}, busy, 1'b0);
        check1({tag, "_done"}, done, 1'b0);
        check1({tag, "_err"}, err, 1'b0);
        check1({tag, "_cpu_reset_n"}, cpu_reset_n, 1'b0);
    endtask

    task automatic fill_random();
        for (int i = 0; i < 256; i++) prog[i] = 8'($urandom);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int len);
        start    = 1'b1;
        load_len = 16'(len);
        tick();
        start    = 1'b0;
        load_len = 16'($urandom);
        @(negedge clk);
        if (len == 0 || len > 64) begin
            check1("start_bad_err", err, 1'b1);
            check1("start_bad_busy", busy, 1'b0);
            check1("start_bad_done", done, 1'b0);
            check1("start_bad_cpu_reset_n", cpu_reset_n, 1'b0);
        end else begin
            check1("start_ok_busy", busy, 1'b1);
            check1("start_ok_ready", byte_ready, 1'b1);
            check1("start_ok_err", err, 1'b0);
            check1("start_ok_done", done, 1'b0);
            check1("start_ok_cpu_reset_n", cpu_reset_n, 1'b0);
        end
        tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic r;
        int   n;
        byte_valid = 1'b1;
        byte_data  = b;
        n = 0;
        forever begin
            @(negedge clk);
            r = byte_ready;
            tick();
            if (r) break;
            n++;
            if (n > 16) begin
                vectors++;
                miscompares++;
                $display("FAIL byte_ready_timeout: got no ready expected ready within 16 cycles at %0t", $time);
                break;
            end
        end
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
    endtask

    // the expected word is pushed once its fourth byte has been handed over
    task automatic send(input int first, input int last, input int maxgap);
        for (int i = first; i < last; i++) begin
            repeat ($urandom_range(maxgap, 0)) tick();
            send_byte(prog[i]);
            if (i % 4 == 3)
                exp_q.push_back('{32'(4 * (i / 4)), {prog[i], prog[i-1], prog[i-2], prog[i-3]}});
        end
    endtask

    task automatic finish_load();
        @(negedge clk);
        check1("write_busy", busy, 1'b1);
        check1("write_wr_en", wr_en, 1'b1);
        check1("write_ready", byte_ready, 1'b0);
        @(negedge clk);
        check1("done_done", done, 1'b1);
        check1("done_cpu_reset_n", cpu_reset_n, 1'b1);
        check1("done_busy", busy, 1'b0);
        check1("done_wr_en", wr_en, 1'b0);
        tick();
    endtask

    task automatic load(input int len, input int maxgap);
        do_start(len);
        send(0, len * 4, maxgap);
        finish_load();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        reset = 1'b1;
        tick();
        check_reset_outputs("idle");

        prog[0] = 8'h13; prog[1] = 8'h00; prog[2] = 8'h00; prog[3] = 8'h00;
        prog[4] = 8'h93; prog[5] = 8'h00; prog[6] = 8'h10; prog[7] = 8'h00;
        load(2, 0);
        load(2, 3);

        do_start(0);
        do_start(65);
        repeat (3) tick();
        check1("err_sticky", err, 1'b1);
        check1("err_cpu_reset_n", cpu_reset_n, 1'b0);

        fill_random();
        do_start(2);
        send(0, 6, 1);
        #2 reset = 1'b0;
        #1 check_reset_outputs("async_rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("held_rst");
        reset = 1'b1;
        tick();
        check_reset_outputs("post_rst");
        fill_random();
        load(2, 2);

        fill_random();
        do_start(2);
        send(0, 2, 1);
        start    = 1'b1;
        load_len = 16'd0;
        tick();
        start = 1'b0;
        @(negedge clk);
        check1("ignored_start_busy", busy, 1'b1);
        check1("ignored_start_err", err, 1'b0);
        tick();
        send(2, 8, 2);
        finish_load();
        fill_random();
        load(1, 1);

        fill_random();
        load(64, 2);

        repeat (8) begin
            if ($urandom_range(3, 0) == 0) begin
                do_start($urandom_range(1, 0) != 0 ? 0 : int'($urandom_range(65535, 65)));
            end else begin
                fill_random();
                load(int'($urandom_range(8, 1)), 3);
            end
        end

        repeat (3) tick();
        check32("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
